// File: rtl/tx_ifm_stream_buffer.sv
// IFM beat FIFO between the fetch path and the MAC array: valid/ready on both sides,
// accumulation-group tracking, flag sanitising and optional read-side lane masking.
module tx_ifm_stream_buffer #(
    parameter int unsigned LANES     = 64,
    parameter int unsigned ELEM_W    = 9,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MASK_ZERO = 1,
    localparam int unsigned DW       = LANES * ELEM_W,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DW-1:0]    in_data_i,
    input  logic [LANES-1:0] in_elem_valid_i,
    input  logic             in_inter_end_i,
    input  logic             in_accum_end_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DW-1:0]    out_data_o,
    output logic [LANES-1:0] out_elem_valid_o,
    output logic             out_inter_end_o,
    output logic             out_accum_end_o,
    output logic [CW-1:0]    count_o,
    output logic [CW-1:0]    group_cnt_o,
    output logic             busy_o,
    output logic             err_flag_o,
    input  logic             err_clr_i
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {StIdle, StRun} state_e;

    logic [DW-1:0]    data_q [DEPTH];
    logic [LANES-1:0] mask_q [DEPTH];
    logic [DEPTH-1:0] inter_q, accum_q;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, group_q, group_d;
    logic          err_q, err_d;
    state_e        state_q, state_d;

    logic push, pop, head_accum, push_group, pop_group, bad_beat;

    assign in_ready_o  = (count_q != CW'(DEPTH)) & ~flush_i;
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign head_accum  = accum_q[rd_ptr_q];
    assign push_group  = push & in_accum_end_i;
    assign pop_group   = pop & head_accum;
    assign bad_beat    = (in_accum_end_i & ~in_inter_end_i) | (in_elem_valid_i == '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        group_d  = group_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
        if (push_group && !pop_group)      group_d = group_q + CW'(1);
        else if (!push_group && pop_group) group_d = group_q - CW'(1);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            group_d  = '0;
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_comb begin
        err_d = err_q;
        if (push && bad_beat) err_d = 1'b1;
        else if (err_clr_i)   err_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (push && !in_accum_end_i) state_d = StRun;
            StRun:  if (push && in_accum_end_i)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush_i) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            group_q  <= '0;
            err_q    <= 1'b0;
            state_q  <= StIdle;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            group_q  <= group_d;
            err_q    <= err_d;
            state_q  <= state_d;
        end
    end

    // Raw data is stored; masking happens only on the read side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
            inter_q <= '0;
            accum_q <= '0;
        end else if (push) begin
            data_q[wr_ptr_q]  <= in_data_i;
            mask_q[wr_ptr_q]  <= in_elem_valid_i;
            inter_q[wr_ptr_q] <= in_inter_end_i | in_accum_end_i;
            accum_q[wr_ptr_q] <= in_accum_end_i;
        end
    end

    always_comb begin
        out_data_o = data_q[rd_ptr_q];
        if (MASK_ZERO != 0) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (!mask_q[rd_ptr_q][i]) out_data_o[i*ELEM_W +: ELEM_W] = '0;
            end
        end
    end

    assign out_elem_valid_o = mask_q[rd_ptr_q];
    assign out_inter_end_o  = inter_q[rd_ptr_q];
    assign out_accum_end_o  = head_accum;
    assign count_o          = count_q;
    assign group_cnt_o      = group_q;
    assign busy_o           = (state_q == StRun);
    assign err_flag_o       = err_q;

endmodule

// File: tb/tb_tx_ifm_stream_buffer.sv
// Bench for tx_ifm_stream_buffer: directed table, hand sequences and random traffic,
// all checked against a queue-based model of the buffer.
module tb_tx_ifm_stream_buffer;
    localparam int unsigned LANES = 64;
    localparam int unsigned EW    = 9;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = LANES * EW;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush, in_valid, in_inter, in_accum, out_ready, err_clr;
    logic [DW-1:0]    in_data;
    logic [LANES-1:0] in_mask;

    logic             in_ready, out_valid, out_inter, out_accum, busy, err_flag;
    logic [DW-1:0]    out_data;
    logic [LANES-1:0] out_mask;
    logic [CW-1:0]    count, group_cnt;

    logic             u2_in_ready, u2_out_valid, u2_out_inter, u2_out_accum, u2_busy, u2_err;
    logic [DW-1:0]    u2_out_data;
    logic [LANES-1:0] u2_out_mask;
    logic [CW-1:0]    u2_count, u2_group;

    tx_ifm_stream_buffer #(.LANES(LANES), .ELEM_W(EW), .DEPTH(DEPTH), .MASK_ZERO(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_elem_valid_i(in_mask), .in_inter_end_i(in_inter),
        .in_accum_end_i(in_accum), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_elem_valid_o(out_mask), .out_inter_end_o(out_inter),
        .out_accum_end_o(out_accum), .count_o(count), .group_cnt_o(group_cnt), .busy_o(busy),
        .err_flag_o(err_flag), .err_clr_i(err_clr)
    );

    // Unmasked variant sharing the same stimulus.
    tx_ifm_stream_buffer #(.LANES(LANES), .ELEM_W(EW), .DEPTH(DEPTH), .MASK_ZERO(0)) dut_raw (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(u2_in_ready), .in_data_i(in_data), .in_elem_valid_i(in_mask),
        .in_inter_end_i(in_inter), .in_accum_end_i(in_accum), .out_valid_o(u2_out_valid),
        .out_ready_i(out_ready), .out_data_o(u2_out_data), .out_elem_valid_o(u2_out_mask),
        .out_inter_end_o(u2_out_inter), .out_accum_end_o(u2_out_accum), .count_o(u2_count),
        .group_cnt_o(u2_group), .busy_o(u2_busy), .err_flag_o(u2_err), .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]    d;
        logic [LANES-1:0] m;
        logic             ie;
        logic             ae;
    } ent_t;

    ent_t q[$];
    logic m_busy, m_err;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic        v, ordy, fl, ec, acc, inter;
        logic [63:0] mask;
        int          exp_cnt, exp_grp;
        logic        exp_busy, exp_err, exp_ov;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] masked(input logic [DW-1:0] d, input logic [LANES-1:0] m);
        logic [DW-1:0] r;
        r = d;
        for (int i = 0; i < LANES; i++) if (!m[i]) r[i*EW +: EW] = '0;
        return r;
    endfunction

    function automatic int groups();
        int n;
        n = 0;
        foreach (q[i]) if (q[i].ae) n++;
        return n;
    endfunction

    task automatic check_model();
        chk("count", DW'(count), DW'(q.size()));
        chk("group_cnt", DW'(group_cnt), DW'(groups()));
        chk("out_valid", DW'(out_valid), DW'(q.size() != 0));
        chk("in_ready", DW'(in_ready), DW'((q.size() != DEPTH) && !flush));
        chk("busy", DW'(busy), DW'(m_busy));
        chk("err_flag", DW'(err_flag), DW'(m_err));
        if (q.size() != 0) begin
            chk("out_data", out_data, masked(q[0].d, q[0].m));
            chk("out_data_raw", u2_out_data, q[0].d);
            chk("out_mask", DW'(out_mask), DW'(q[0].m));
            chk("out_inter", DW'(out_inter), DW'(q[0].ie));
            chk("out_accum", DW'(out_accum), DW'(q[0].ae));
        end
    endtask

    task automatic check_reset();
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_count", DW'(count), '0);
        chk("rst_group", DW'(group_cnt), '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_err", DW'(err_flag), '0);
        chk("rst_data", out_data, '0);
        chk("rst_mask", DW'(out_mask), '0);
        chk("rst_flags", DW'({out_inter, out_accum}), '0);
    endtask

    // One clock: update the model from the inputs sampled at the edge, then compare.
    task automatic cycle();
        ent_t e;
        bit   m_ready, m_push, m_pop;
        @(posedge clk);
        m_ready = (q.size() != DEPTH) && !flush;
        m_push  = in_valid && m_ready;
        m_pop   = (q.size() != 0) && out_ready;
        if (flush) begin
            q.delete();
            m_busy = 1'b0;
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                e.d = in_data;
                e.m = in_mask;
                e.ie = in_inter | in_accum;
                e.ae = in_accum;
                q.push_back(e);
                m_busy = !in_accum;
            end
        end
        if (m_push && ((in_accum && !in_inter) || in_mask == '0)) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        #1;
        check_model();
    endtask

    task automatic drive(input logic v, input logic ordy, input logic acc, input logic inter,
                         input logic [LANES-1:0] m, input logic [DW-1:0] d);
        in_valid  = v;
        out_ready = ordy;
        in_accum  = acc;
        in_inter  = inter;
        in_mask   = m;
        in_data   = d;
        flush     = 1'b0;
        err_clr   = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic drain();
        drive(1'b0, 1'b1, 1'b0, 1'b0, '1, '0);
        for (int i = 0; i < DEPTH + 2 && q.size() != 0; i++) cycle();
        chk("drain_empty", DW'(out_valid), '0);
    endtask

    task automatic push_n(input int n, input logic acc);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, acc, 1'b0, '1, rand_data());
            cycle();
        end
    endtask

    initial begin
        logic [DW-1:0] exp_d, all155;
        logic [8:0]    lv;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        m_busy = 1'b0;
        m_err  = 1'b0;
        #12;
        check_reset();
        rst_n = 1'b1;

        tbl[0] = '{1, 0, 0, 0, 1, 1, 64'h1,  1, 1, 0, 0, 1};
        tbl[1] = '{1, 0, 0, 0, 0, 0, '1,     2, 1, 1, 0, 1};
        tbl[2] = '{1, 0, 0, 0, 1, 0, '1,     3, 2, 0, 1, 1};
        tbl[3] = '{0, 1, 0, 0, 0, 0, '1,     2, 1, 0, 1, 1};
        tbl[4] = '{0, 0, 0, 1, 0, 0, '1,     2, 1, 0, 0, 1};
        tbl[5] = '{1, 0, 0, 1, 0, 1, 64'h0,  3, 1, 1, 1, 1};
        tbl[6] = '{1, 0, 0, 0, 0, 0, '1,     4, 1, 1, 1, 1};
        tbl[7] = '{1, 1, 0, 0, 1, 1, '1,     3, 1, 1, 1, 1};
        tbl[8] = '{1, 0, 1, 0, 0, 0, '1,     0, 0, 0, 1, 0};
        tbl[9] = '{0, 0, 0, 1, 0, 0, '1,     0, 0, 0, 0, 0};
        for (int k = 0; k < 10; k++) begin
            lv = 9'h1FF - 9'(k);
            drive(tbl[k].v, tbl[k].ordy, tbl[k].acc, tbl[k].inter, tbl[k].mask, {LANES{lv}});
            flush   = tbl[k].fl;
            err_clr = tbl[k].ec;
            cycle();
            chk($sformatf("tbl%0d_count", k), DW'(count), DW'(tbl[k].exp_cnt));
            chk($sformatf("tbl%0d_group", k), DW'(group_cnt), DW'(tbl[k].exp_grp));
            chk($sformatf("tbl%0d_busy", k), DW'(busy), DW'(tbl[k].exp_busy));
            chk($sformatf("tbl%0d_err", k), DW'(err_flag), DW'(tbl[k].exp_err));
            chk($sformatf("tbl%0d_ovalid", k), DW'(out_valid), DW'(tbl[k].exp_ov));
            if (k == 0) chk("tbl0_lane0", DW'(out_data[8:0]), DW'(9'h1FF));
        end

        // Fill to full, then pop with in_valid held: no pass-through while full.
        push_n(DEPTH, 1'b0);
        chk("full_ready", DW'(in_ready), '0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, '1, rand_data());
        cycle();
        chk("after_pop_ready", DW'(in_ready), DW'(1));
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, '1, rand_data());
            cycle();
        end
        drain();

        // Steady push+pop at count 2.
        push_n(2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'(i % 2), 1'b1, '1, rand_data());
            cycle();
            chk("steady_count", DW'(count), DW'(2));
        end
        drain();

        // Masking: alternating mask, lane 0 invalid.
        lv = 9'h155;
        all155 = {LANES{lv}};
        drive(1'b1, 1'b0, 1'b1, 1'b1, {(LANES / 2){2'b10}}, all155);
        cycle();
        exp_d = '0;
        for (int i = 1; i < LANES; i += 2) exp_d[i*EW +: EW] = 9'h155;
        chk("mask_zero1", out_data, exp_d);
        chk("mask_zero0", u2_out_data, all155);
        drain();

        // Flush mid-group with a concurrent beat.
        push_n(3, 1'b0);
        chk("grp_busy", DW'(busy), DW'(1));
        chk("grp_count", DW'(count), DW'(3));
        drive(1'b1, 1'b0, 1'b1, 1'b1, '1, {LANES{9'h0AA}});
        flush = 1'b1;
        cycle();
        chk("flush_count", DW'(count), '0);
        chk("flush_ovalid", DW'(out_valid), '0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, '1, {LANES{9'h033}});
        cycle();
        chk("flush_next_head", out_data, {LANES{9'h033}});
        drain();

        // Asynchronous reset mid-group, with the error flag set beforehand.
        push_n(2, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, '0, rand_data());
        cycle();
        chk("pre_rst_err", DW'(err_flag), DW'(1));
        drive(1'b1, 1'b0, 1'b1, 1'b1, '1, rand_data());
        rst_n = 1'b0;
        #2;
        q.delete();
        m_busy = 1'b0;
        m_err  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        check_reset();
        #4;
        rst_n = 1'b1;
        cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 3) == 0,
                  1'($urandom % 2), (($urandom % 10) == 0) ? '0 : {$urandom(), $urandom()},
                  rand_data());
            flush   = ($urandom % 40) == 0;
            err_clr = ($urandom % 16) == 0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end within the time limit");
        $fatal(1);
    end

endmodule
